// File: rtl/bitwise_lane_pipe.sv
// Multi-lane bitwise logic unit: per-channel NOT/AND/OR/XOR against a shared mask,
// carried through a two-stage valid/ready pipeline with a wrapping transfer counter.
module bitwise_lane_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [1:0]                 in_op,
    input  logic [WIDTH-1:0]           in_mask,
    input  logic [CHANNELS-1:0]        in_chan_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*WIDTH-1:0]  out_data,
    output logic [15:0]                out_count
);

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    op_e                       op;
    logic [CHANNELS*WIDTH-1:0] result;
    logic [CHANNELS*WIDTH-1:0] s1_data;
    logic                      s1_valid;
    logic                      s2_valid;
    logic                      s2_adv;
    logic                      accept;
    logic                      xfer;

    assign op = op_e'(in_op);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic d;
            logic r;

            assign d = in_data[c*WIDTH + i];

            always_comb begin
                r = d;
                if (in_chan_en[c]) begin
                    unique case (op)
                        OP_NOT: r = ~d;
                        OP_AND: r = d & in_mask[i];
                        OP_OR:  r = d | in_mask[i];
                        OP_XOR: r = d ^ in_mask[i];
                    endcase
                end
            end

            assign result[c*WIDTH + i] = r;
        end
    end

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = rst_n && (!s1_valid || s2_adv);
    assign accept    = in_valid && in_ready;
    assign xfer      = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // out_data only reloads from a valid s1 so an idle output keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s1_data;
                end
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= result;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (xfer) begin
                out_count <= out_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_lane_pipe.sv
// Scoreboard bench for bitwise_lane_pipe (WIDTH=4, CHANNELS=2): driver pushes expected
// beats on acceptance, a negedge monitor checks data, order, latency, handshake and count.
module tb_bitwise_lane_pipe;

    localparam int unsigned W  = 4;
    localparam int unsigned CH = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [1:0]    in_op;
    logic [3:0]    in_mask;
    logic [1:0]    in_chan_en;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [15:0]   out_count;

    bitwise_lane_pipe #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_mask    (in_mask),
        .in_chan_en (in_chan_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  data;
        int unsigned acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc       = 0;
    int unsigned errors    = 0;
    int unsigned checks    = 0;
    logic [15:0] model_cnt = '0;
    bit          prev_rst_low = 1'b0;
    bit          prev_hold    = 1'b0;
    logic [7:0]  prev_data    = '0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: everything is sampled on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        cyc++;
        exp_rdy = rst_n && ((q.size() < 2) || out_ready);
        check(out_count === model_cnt, "out_count", 32'(out_count), 32'(model_cnt));
        check(in_ready === exp_rdy, "in_ready", 32'(in_ready), 32'(exp_rdy));
        if (prev_rst_low) begin
            check(out_valid === 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
            check(out_data === 8'h00, "reset_out_data", 32'(out_data), 32'd0);
        end
        if (prev_hold) begin
            check(out_valid === 1'b1, "hold_valid", 32'(out_valid), 32'd1);
            check(out_data === prev_data, "hold_data", 32'(out_data), 32'(prev_data));
        end
        if (!rst_n) begin
            q.delete();
            model_cnt = '0;
        end else if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check(1'b0, "unexpected_beat", 32'(out_data), 32'd0);
            end else begin
                e = q.pop_front();
                check(out_data === e.data, "out_data", 32'(out_data), 32'(e.data));
                if (e.lat) begin
                    check(cyc == e.acc + 2, "latency", cyc - e.acc, 32'd2);
                end
            end
            model_cnt = model_cnt + 16'd1;
        end
        prev_rst_low = !rst_n;
        prev_hold    = rst_n && out_valid && !out_ready;
        prev_data    = out_data;
    end

    task automatic send(input logic [7:0] d, input logic [1:0] op, input logic [3:0] m,
                        input logic [1:0] en, input logic [7:0] exp, input bit lat);
        exp_t e;
        in_valid   = 1'b1;
        in_data    = d;
        in_op      = op;
        in_mask    = m;
        in_chan_en = en;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 40) begin
                $display("FAIL send_timeout: got in_ready=0 expected acceptance of %0h", d);
                $fatal(1);
            end
        end
        @(posedge clk);
        e.data = exp;
        e.acc  = cyc;
        e.lat  = lat;
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_op      = '0;
        in_mask    = '0;
        in_chan_en = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beats: NOT on both lanes, XOR with only the low lane enabled.
        send(8'hCA, 2'b00, 4'h0, 2'b11, 8'h35, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(8'hA5, 2'b11, 4'hF, 2'b01, 8'hAA, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back stream, one beat per cycle.
        send(8'hCA, 2'b01, 4'hA, 2'b11, 8'h8A, 1'b1);
        send(8'h0A, 2'b10, 4'h5, 2'b11, 8'h5F, 1'b1);
        send(8'h6C, 2'b01, 4'h3, 2'b10, 8'h2C, 1'b1);
        send(8'h5A, 2'b10, 4'h0, 2'b00, 8'h5A, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure to full, then release with the third beat waiting.
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 2'b00, 4'h0, 2'b11, 8'hFE, 1'b0);
                send(8'h02, 2'b00, 4'h0, 2'b11, 8'hFD, 1'b0);
                send(8'h03, 2'b00, 4'h0, 2'b11, 8'hFC, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats buffered and a beat offered during reset.
        out_ready = 1'b0;
        send(8'h11, 2'b00, 4'h0, 2'b11, 8'hEE, 1'b0);
        send(8'h22, 2'b00, 4'h0, 2'b11, 8'hDD, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(8'h3C, 2'b11, 4'h6, 2'b11, 8'h5A, 1'b1);

        for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
            $fatal(1);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
